// File: rtl/bsg_counter_window_sampler.sv
`default_nettype none
// ============================================================================
// Module   : bsg_counter_window_sampler
// Brief    : Sequences an external clear/up counter over fixed windows of
//            window_p cycles. At each window end the counter value is
//            captured and offered downstream with a valid/ready handshake.
//            Samples overwritten before acceptance are counted (saturating).
// Options  : BSG_COUNTER_WINDOW_SAMPLER_SAT_EN - block up_o while the paired
//            counter sits at max_val_p so the window count saturates.
// Revision : 1.0 - initial release
// ============================================================================
module bsg_counter_window_sampler #(
   parameter int  window_p  = 16,
   parameter int  max_val_p = 64,
   localparam int c_CNT_W   = $clog2(max_val_p + 1),
   localparam int c_WT_W    = $clog2(window_p)
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic               en_i,
   input  logic               event_i,
   input  logic [c_CNT_W-1:0] count_i,
   output logic               up_o,
   output logic               clear_o,
   output logic               sample_v_o,
   output logic [c_CNT_W-1:0] sample_data_o,
   input  logic               sample_ready_i,
   output logic [3:0]         drop_count_o
);

   localparam logic [0:0]        c_IDLE    = 1'b0;
   localparam logic [0:0]        c_RUN     = 1'b1;
   localparam logic [c_WT_W-1:0] c_WT_LAST = c_WT_W'(window_p - 1);
   localparam logic [3:0]        c_DROP_MAX = 4'hF;

   logic [0:0]         r_state;
   logic [c_WT_W-1:0]  r_wt;
   logic               r_v;
   logic [c_CNT_W-1:0] r_data;
   logic [3:0]         r_drop;

   logic w_run;
   logic w_start;
   logic w_abort;
   logic w_win_end;
   logic w_accept;
   logic w_at_max;

   assign w_run     = (r_state == c_RUN);
   assign w_start   = !w_run && en_i;
   assign w_abort   = w_run && !en_i;
   // A window end captures even if enable drops in the same cycle.
   assign w_win_end = w_run && (r_wt == c_WT_LAST);
   assign w_accept  = r_v && sample_ready_i;

`ifdef BSG_COUNTER_WINDOW_SAMPLER_SAT_EN
   localparam logic [c_CNT_W-1:0] c_MAX = c_CNT_W'(max_val_p);
   assign w_at_max = (count_i == c_MAX);
`else
   assign w_at_max = 1'b0;
`endif

   // Counter controls: held in clear with no increments while reset is low.
   // An event on a clear cycle lands in the next window (count*~clear+up).
   assign up_o    = reset_n_i && event_i && (w_run || en_i) && !w_at_max;
   assign clear_o = !reset_n_i || w_start || w_abort || w_win_end;

   assign sample_v_o    = r_v;
   assign sample_data_o = r_data;
   assign drop_count_o  = r_drop;

   // Window sequencing: IDLE waits for enable, RUN steps the window timer.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state <= c_IDLE;
         r_wt    <= '0;
      end else begin
         case (r_state)
            c_IDLE: begin
               r_wt <= '0;
               if (en_i) begin
                  r_state <= c_RUN;
               end
            end
            c_RUN: begin
               if (!en_i) begin
                  r_state <= c_IDLE;
                  r_wt    <= '0;
               end else if (w_win_end) begin
                  r_wt <= '0;
               end else begin
                  r_wt <= r_wt + 1'b1;
               end
            end
            default: begin
               r_state <= c_IDLE;
               r_wt    <= '0;
            end
         endcase
      end
   end

   // Sample register: a capture always wins, otherwise an accept empties it.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_v    <= 1'b0;
         r_data <= '0;
      end else if (w_win_end) begin
         r_v    <= 1'b1;
         r_data <= count_i;
      end else if (w_accept) begin
         r_v <= 1'b0;
      end
   end

   // Drop counter: a capture over an unaccepted sample loses the old one.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_drop <= '0;
      end else if (w_start) begin
         r_drop <= '0;
      end else if (w_win_end && r_v && !sample_ready_i && (r_drop != c_DROP_MAX)) begin
         r_drop <= r_drop + 4'd1;
      end
   end

endmodule
`default_nettype wire
